// File: rtl/winograd_tile_linebuf_pkg.sv
// Shared types and helpers for the Winograd tile line buffer.
//   state_e      : frame sequencing states
//   DEF_*        : default pixel width / tile geometry
//   is_emit_row  : true when a raster row completes a tile that must be emitted
package winograd_tile_linebuf_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_TILE   = 4;
  localparam int DEF_STRIDE = 2;

  // The first emittable row is TILE-1 (the first with a full column behind it);
  // from there every STRIDE-th row starts a tile.
  function automatic logic is_emit_row(input int row, input int tile, input int stride);
    if (row < tile - 1) return 1'b0;
    return ((row - (tile - 1)) % stride) == 0;
  endfunction

endpackage

// File: rtl/winograd_tile_linebuf_line_ram.sv
// One line of pixel history: simple dual-port synchronous RAM.
//   clock, reset_n          : clock, async active-low reset (read register only)
//   i_wr_en/addr/data       : write port
//   i_rd_en/addr, o_rd_data : read port, one-cycle latency, holds when i_rd_en=0
// A read and write to the same address in one cycle returns the old contents.
module winograd_tile_linebuf_line_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 640,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rd_data;

  always_ff @(posedge clock) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  // Read register is reset so the assembled output column is zero out of reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)     r_rd_data <= '0;
    else if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/winograd_tile_linebuf.sv
// Streaming line buffer feeding the Winograd input transform.
// Keeps TILE-1 previous rows and, on tile-start rows, emits one vertical
// TILE-pixel column per accepted pixel.
//   clock, reset_n            : clock, async active-low reset
//   io_start, io_clear        : start frame (IDLE only), synchronous abort
//   io_in_valid/ready/data    : raster pixel input
//   io_out_valid/ready        : column output handshake
//   io_out_col                : slice k = row r-TILE+1+k, top slice is the live pixel
//   io_out_col_idx/row_idx    : pixel column and tile-row index of the emitted column
//   io_frame_done, io_busy    : end-of-frame pulse, not-idle status
//
// state | meaning
// IDLE  | waiting for io_start, counters held at 0
// FILL  | loading the first TILE-1 rows, no output
// RUN   | streaming, emitting columns on tile-start rows
// DONE  | one-cycle end-of-frame pulse
module winograd_tile_linebuf
  import winograd_tile_linebuf_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 360,
  parameter int TILE   = DEF_TILE,
  parameter int STRIDE = DEF_STRIDE,
  parameter int COL_W  = $clog2(IMG_W),
  parameter int ROW_W  = $clog2(IMG_H)
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   io_start,
  input  logic                   io_clear,
  input  logic                   io_in_valid,
  output logic                   io_in_ready,
  input  logic [DATA_W-1:0]      io_in_data,
  output logic                   io_out_valid,
  input  logic                   io_out_ready,
  output logic [TILE*DATA_W-1:0] io_out_col,
  output logic [COL_W-1:0]       io_out_col_idx,
  output logic [ROW_W-1:0]       io_out_row_idx,
  output logic                   io_frame_done,
  output logic                   io_busy
);

  localparam int NRAM  = TILE - 1;
  localparam int PTR_W = (NRAM > 1) ? $clog2(NRAM) : 1;

  localparam logic [COL_W-1:0] COL_LAST      = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST      = ROW_W'(IMG_H - 1);
  localparam logic [ROW_W-1:0] FILL_LAST_ROW = ROW_W'(TILE - 2);
  localparam logic [PTR_W-1:0] PTR_LAST      = PTR_W'(NRAM - 1);

  state_e r_state, w_state_nxt;

  logic [COL_W-1:0]  r_col;
  logic [ROW_W-1:0]  r_row;
  logic [ROW_W-1:0]  r_trow;
  logic [PTR_W-1:0]  r_ptr;
  logic              r_all_in;

  logic              r_out_valid;
  logic [COL_W-1:0]  r_out_col_idx;
  logic [ROW_W-1:0]  r_out_row_idx;
  logic [DATA_W-1:0] r_live;
  logic [PTR_W-1:0]  r_ptr_q;

  logic              w_acc;
  logic              w_run_acc;
  logic              w_col_end;
  logic              w_fill_end;
  logic              w_emit;
  logic [DATA_W-1:0] w_ram_q [NRAM];
  logic [TILE*DATA_W-1:0] w_col;

  assign w_acc      = io_in_valid && io_in_ready;
  assign w_run_acc  = w_acc && (r_state == RUN);
  assign w_col_end  = (r_col == COL_LAST);
  assign w_fill_end = w_acc && (r_state == FILL) && w_col_end && (r_row == FILL_LAST_ROW);
  assign w_emit     = is_emit_row(int'(r_row), TILE, STRIDE);

  // FSM: state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    if (io_clear) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (io_start) w_state_nxt = FILL;
        FILL:    if (w_fill_end) w_state_nxt = RUN;
        // Leave RUN only once the last column has left the output register.
        RUN:     if (r_all_in && !r_out_valid) w_state_nxt = DONE;
        DONE:    w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    io_busy       = (r_state != IDLE);
    io_frame_done = (r_state == DONE);
    io_in_ready   = 1'b0;
    case (r_state)
      FILL:    io_in_ready = 1'b1;
      RUN:     io_in_ready = !r_all_in && (!r_out_valid || io_out_ready);
      default: io_in_ready = 1'b0;
    endcase
  end

  // Raster position, line-RAM row pointer and tile-row index.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_col    <= '0;
      r_row    <= '0;
      r_trow   <= '0;
      r_ptr    <= '0;
      r_all_in <= 1'b0;
    end else if (io_clear || (r_state == IDLE) || (r_state == DONE)) begin
      r_col    <= '0;
      r_row    <= '0;
      r_trow   <= '0;
      r_ptr    <= '0;
      r_all_in <= 1'b0;
    end else if (w_acc) begin
      if (w_col_end) begin
        r_col <= '0;
        if (r_row == ROW_LAST) begin
          // Row counter parks on the last row; the flag ends input for the frame.
          r_all_in <= 1'b1;
        end else begin
          r_row <= r_row + ROW_W'(1);
          r_ptr <= (r_ptr == PTR_LAST) ? '0 : r_ptr + PTR_W'(1);
          if ((r_state == RUN) && w_emit) r_trow <= r_trow + ROW_W'(1);
        end
      end else begin
        r_col <= r_col + COL_W'(1);
      end
    end
  end

  // Output register. The RAM read registers are only re-read on an accepted
  // pixel, and no pixel is accepted while a column is stalled, so the RAM
  // outputs hold together with these registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_out_valid   <= 1'b0;
      r_out_col_idx <= '0;
      r_out_row_idx <= '0;
      r_live        <= '0;
      r_ptr_q       <= '0;
    end else if (io_clear) begin
      r_out_valid <= 1'b0;
    end else if (w_run_acc && w_emit) begin
      r_out_valid   <= 1'b1;
      r_out_col_idx <= r_col;
      r_out_row_idx <= r_trow;
      r_live        <= io_in_data;
      r_ptr_q       <= r_ptr;
    end else if (io_out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  for (genvar g = 0; g < NRAM; g++) begin : g_ram
    winograd_tile_linebuf_line_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (IMG_W),
      .ADDR_W (COL_W)
    ) u_line_ram (
      .clock     (clock),
      .reset_n   (reset_n),
      .i_wr_en   (w_acc && (r_ptr == PTR_W'(g))),
      .i_wr_addr (r_col),
      .i_wr_data (io_in_data),
      .i_rd_en   (w_run_acc),
      .i_rd_addr (r_col),
      .o_rd_data (w_ram_q[g])
    );
  end

  // RAM at the captured pointer holds the oldest row; successive RAMs (mod
  // TILE-1) hold successively newer rows.
  always_comb begin
    w_col = '0;
    w_col[TILE*DATA_W-1 -: DATA_W] = r_live;
    for (int k = 0; k < NRAM; k++) begin
      for (int j = 0; j < NRAM; j++) begin
        if (((int'(r_ptr_q) + k) % NRAM) == j) w_col[k*DATA_W +: DATA_W] = w_ram_q[j];
      end
    end
  end

  assign io_out_valid   = r_out_valid;
  assign io_out_col     = w_col;
  assign io_out_col_idx = r_out_col_idx;
  assign io_out_row_idx = r_out_row_idx;

endmodule

// File: tb/tb_winograd_tile_linebuf.sv
module tb_winograd_tile_linebuf;

  localparam int DW = 8;
  localparam int IW = 8;
  localparam int IH = 6;
  localparam int TL = 4;
  localparam int ST = 2;
  localparam int CW = $clog2(IW);
  localparam int RW = $clog2(IH);

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic io_start = 1'b0;
  logic io_clear = 1'b0;
  logic io_in_valid = 1'b0;
  logic io_out_ready = 1'b0;
  logic [DW-1:0] io_in_data = '0;
  logic io_in_ready, io_out_valid, io_frame_done, io_busy;
  logic [TL*DW-1:0] io_out_col;
  logic [CW-1:0] io_out_col_idx;
  logic [RW-1:0] io_out_row_idx;

  winograd_tile_linebuf #(
    .DATA_W (DW), .IMG_W (IW), .IMG_H (IH), .TILE (TL), .STRIDE (ST)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .io_start       (io_start),
    .io_clear       (io_clear),
    .io_in_valid    (io_in_valid),
    .io_in_ready    (io_in_ready),
    .io_in_data     (io_in_data),
    .io_out_valid   (io_out_valid),
    .io_out_ready   (io_out_ready),
    .io_out_col     (io_out_col),
    .io_out_col_idx (io_out_col_idx),
    .io_out_row_idx (io_out_row_idx),
    .io_frame_done  (io_frame_done),
    .io_busy        (io_busy)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  int m_row, m_col, last_row;
  int n_out, n_valid_seen, n_row4_valid, n_done;
  logic acc_in, acc_out;
  logic [7:0] img [IH][IW];
  logic [31:0] q_col[$];
  logic [31:0] q_ci[$];
  logic [31:0] q_ri[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_row = 0; m_col = 0; last_row = -1;
    q_col.delete(); q_ci.delete(); q_ri.delete();
    n_out = 0; n_valid_seen = 0; n_row4_valid = 0; n_done = 0;
  endtask

  // Image model: column = this pixel over the three pixels above it.
  task automatic model_push(input logic [7:0] d);
    img[m_row][m_col] = d;
    last_row = m_row;
    if (m_row >= TL - 1 && ((m_row - (TL - 1)) % ST) == 0) begin
      q_col.push_back({img[m_row][m_col], img[m_row-1][m_col],
                       img[m_row-2][m_col], img[m_row-3][m_col]});
      q_ci.push_back(32'(m_col));
      q_ri.push_back(32'((m_row - (TL - 1)) / ST));
    end
    if (m_col == IW - 1) begin m_col = 0; m_row++; end
    else m_col++;
  endtask

  // One clock: drive, sample handshakes, score, advance past the edge.
  task automatic cyc(input logic v, input logic [7:0] d, input logic r);
    io_in_valid = v; io_in_data = d; io_out_ready = r;
    #1;
    acc_in  = v && io_in_ready;
    acc_out = io_out_valid && r;
    if (acc_out) begin
      if (q_col.size() == 0) begin
        chk("sb_unexpected_col", 32'(io_out_valid), 32'd0);
      end else begin
        chk("sb_col", io_out_col, q_col.pop_front());
        chk("sb_col_idx", 32'(io_out_col_idx), q_ci.pop_front());
        chk("sb_row_idx", 32'(io_out_row_idx), q_ri.pop_front());
        n_out++;
      end
    end
    @(posedge clock);
    #1;
    if (io_out_valid) n_valid_seen++;
    if (io_frame_done) n_done++;
    if (acc_in) begin
      model_push(d);
      if (last_row == 4 && io_out_valid) n_row4_valid++;
    end
  endtask

  // mode 0: pixel = row*16+col; 1: random data with random gaps; 2: inverted pattern
  task automatic feed(input int n, input int mode);
    int got = 0;
    int budget = 2000;
    logic v, r;
    logic [7:0] d;
    while (got < n && budget > 0) begin
      budget--;
      v = (mode == 1) ? ($urandom_range(99) >= 30) : 1'b1;
      r = (mode == 1) ? ($urandom_range(99) >= 30) : 1'b1;
      d = (mode == 1) ? 8'($urandom) : (mode == 2) ? ~8'(m_row*16 + m_col) : 8'(m_row*16 + m_col);
      cyc(v, d, r);
      if (acc_in) got++;
    end
    chk("feed_accepted", 32'(got), 32'(n));
  endtask

  task automatic start_frame();
    model_reset();
    io_start = 1'b1;
    cyc(1'b0, 8'h00, 1'b1);
    io_start = 1'b0;
    chk("start_busy", 32'(io_busy), 32'd1);
  endtask

  task automatic finish_frame();
    int b = 0;
    while (n_done == 0 && b < 40) begin cyc(1'b0, 8'h00, 1'b1); b++; end
    repeat (3) cyc(1'b0, 8'h00, 1'b1);
    chk("frame_done_pulses", 32'(n_done), 32'd1);
    chk("frame_busy_after", 32'(io_busy), 32'd0);
    chk("frame_columns", 32'(n_out), 32'd16);
    chk("frame_sb_empty", 32'(q_col.size()), 32'd0);
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_out_valid", 32'(io_out_valid), 32'd0);
    chk("rst_in_ready", 32'(io_in_ready), 32'd0);
    chk("rst_busy", 32'(io_busy), 32'd0);
    chk("rst_frame_done", 32'(io_frame_done), 32'd0);
    chk("rst_out_col", io_out_col, 32'd0);
    chk("rst_col_idx", 32'(io_out_col_idx), 32'd0);
    chk("rst_row_idx", 32'(io_out_row_idx), 32'd0);
    reset_n = 1'b1;
    @(posedge clock); #1;

    // 1+2: fill latency, first column, stride rows, last column, frame end
    start_frame();
    chk("fill_in_ready", 32'(io_in_ready), 32'd1);
    feed(24, 0);
    chk("fill_no_valid", 32'(n_valid_seen), 32'd0);
    feed(1, 0);
    chk("t1_valid", 32'(io_out_valid), 32'd1);
    chk("t1_col", io_out_col, 32'h30201000);
    chk("t1_col_idx", 32'(io_out_col_idx), 32'd0);
    chk("t1_row_idx", 32'(io_out_row_idx), 32'd0);
    feed(23, 0);
    chk("t2_valid", 32'(io_out_valid), 32'd1);
    chk("t2_col", io_out_col, 32'h57473727);
    chk("t2_col_idx", 32'(io_out_col_idx), 32'd7);
    chk("t2_row_idx", 32'(io_out_row_idx), 32'd1);
    chk("t2_in_ready_after_last", 32'(io_in_ready), 32'd1 - 32'(io_out_valid));
    chk("t2_row4_silent", 32'(n_row4_valid), 32'd0);
    finish_frame();

    // 3: backpressure at row 3 col 2
    start_frame();
    feed(27, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 8'(m_row*16 + m_col), 1'b0);
      chk("bp_valid", 32'(io_out_valid), 32'd1);
      chk("bp_col", io_out_col, 32'h32221202);
      chk("bp_col_idx", 32'(io_out_col_idx), 32'd2);
      chk("bp_in_ready", 32'(io_in_ready), 32'd0);
    end
    feed(21, 0);
    finish_frame();

    // 4: async reset mid-RUN, then a clean frame
    start_frame();
    feed(28, 0);
    reset_n = 1'b0;
    #1;
    chk("ar_out_valid", 32'(io_out_valid), 32'd0);
    chk("ar_in_ready", 32'(io_in_ready), 32'd0);
    chk("ar_busy", 32'(io_busy), 32'd0);
    chk("ar_out_col", io_out_col, 32'd0);
    chk("ar_col_idx", 32'(io_out_col_idx), 32'd0);
    chk("ar_row_idx", 32'(io_out_row_idx), 32'd0);
    @(posedge clock); #2;
    reset_n = 1'b1;
    @(posedge clock); #1;
    start_frame();
    feed(24, 0);
    chk("ar_fill_no_valid", 32'(n_valid_seen), 32'd0);
    feed(1, 0);
    chk("ar_first_col", io_out_col, 32'h30201000);
    feed(23, 0);
    finish_frame();

    // 5: clear mid-FILL after 10 stale pixels, restart with fresh data
    start_frame();
    feed(10, 2);
    io_clear = 1'b1;
    cyc(1'b0, 8'h00, 1'b1);
    io_clear = 1'b0;
    chk("clr_busy", 32'(io_busy), 32'd0);
    chk("clr_in_ready", 32'(io_in_ready), 32'd0);
    chk("clr_out_valid", 32'(io_out_valid), 32'd0);
    start_frame();
    feed(25, 0);
    chk("clr_first_col", io_out_col, 32'h30201000);
    feed(23, 0);
    finish_frame();

    // 6: random data and gaps, two back-to-back frames
    for (int f = 0; f < 2; f++) begin
      start_frame();
      feed(IW*IH, 1);
      finish_frame();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
